// File: rtl/usb2_pkg.sv
// usb2_pkg: shared FSM encoding, endpoint index type and limits for the endpoint router
package usb2_pkg;
  localparam int USB2_MAX_EP = 15;
  typedef logic [3:0] usb2_sel_t;
  typedef enum logic [1:0] {ST_IDLE, ST_XFER_IN, ST_XFER_OUT, ST_DONE} usb2_state_t;
endpackage

// File: rtl/usb2_ep_ready_track.sv
// usb2_ep_ready_track: per-endpoint ready edge register, ready latch and sticky missed-ready flag
module usb2_ep_ready_track (
  input  logic phy_clk,
  input  logic reset_n,
  input  logic ready,
  input  logic clr,
  input  logic soft_rst,
  input  logic err_clr,
  output logic latch,
  output logic err
);
  logic r_rdy, r_edge, r_latch, r_err;
  logic w_clr;
  assign w_clr = clr | soft_rst;
  // the edge is registered so a ready rise reaches the latch one cycle later
  always_ff @(posedge phy_clk or negedge reset_n)
    if (!reset_n) begin
      r_rdy   <= 1'b0;
      r_edge  <= 1'b0;
      r_latch <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_rdy   <= ready;
      r_edge  <= ready & ~r_rdy;
      r_latch <= ~soft_rst & (r_edge | (r_latch & ~clr));
      r_err   <= (r_edge & r_latch & ~w_clr) | (r_err & ~err_clr);
    end
  assign latch = r_latch;
  assign err   = r_err;
endmodule

// File: rtl/usb2_ep_router.sv
// usb2_ep_router: latches the target endpoint per transaction and steers strobes, PID and buffer ports
module usb2_ep_router
  import usb2_pkg::*;
#(
  parameter int NUM_EP = 4,
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 10
) (
  input  logic                    phy_clk,
  input  logic                    reset_n,
  input  logic                    se0_reset,
  input  logic                    xfer_in,
  input  logic                    xfer_out,
  input  logic [3:0]              xfer_endp,
  input  logic [3:0]              xfer_pid,
  output logic                    xfer_ready,
  output logic                    xfer_nak,
  input  logic [ADDR_W-1:0]       buf_in_addr,
  input  logic [7:0]              buf_in_data,
  input  logic                    buf_in_wren,
  input  logic [ADDR_W-1:0]       buf_out_addr,
  output logic [7:0]              buf_out_q,
  output logic [LEN_W-1:0]        buf_out_len,
  input  logic [NUM_EP-1:0]       ep_enable,
  output logic [NUM_EP-1:0]       ep_xfer_in,
  output logic [NUM_EP-1:0]       ep_xfer_out,
  output logic [4*NUM_EP-1:0]     ep_xfer_pid,
  input  logic [NUM_EP-1:0]       ep_xfer_ready,
  output logic [ADDR_W-1:0]       ep_buf_in_addr,
  output logic [7:0]              ep_buf_in_data,
  output logic [NUM_EP-1:0]       ep_buf_in_wren,
  output logic [ADDR_W-1:0]       ep_buf_out_addr,
  input  logic [8*NUM_EP-1:0]     ep_buf_out_q,
  input  logic [LEN_W*NUM_EP-1:0] ep_buf_out_len,
  input  logic                    err_clr,
  output logic [NUM_EP-1:0]       err_missed_ep_ready
);
  usb2_state_t          r_state;
  usb2_sel_t            r_sel;
  logic                 r_sel_valid, r_xin, r_xout;
  logic [1:0]           r_rst_sync;
  logic                 w_in_rise, w_out_rise;
  logic [USB2_MAX_EP:0] w_en_ext;
  logic [NUM_EP-1:0]    w_hit, w_latch, w_clr;
  assign w_in_rise  = xfer_in & ~r_xin;
  assign w_out_rise = xfer_out & ~r_xout;
  // zero-extended mask makes out-of-range endpoint numbers read as disabled
  assign w_en_ext   = {{(USB2_MAX_EP+1-NUM_EP){1'b0}}, ep_enable};
  always_ff @(posedge phy_clk or negedge reset_n)
    if (!reset_n) begin
      r_rst_sync  <= 2'b00;
      r_xin       <= 1'b0;
      r_xout      <= 1'b0;
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_sel_valid <= 1'b0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
      r_xin      <= xfer_in;
      r_xout     <= xfer_out;
      if (se0_reset) begin
        r_state     <= ST_IDLE;
        r_sel_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: if (r_rst_sync[1] && (w_in_rise || w_out_rise)) begin
            r_state     <= w_in_rise ? ST_XFER_IN : ST_XFER_OUT;
            r_sel       <= xfer_endp;
            r_sel_valid <= w_en_ext[xfer_endp];
          end
          ST_XFER_IN:  if (!xfer_in) r_state <= ST_DONE;
          ST_XFER_OUT: if (!xfer_out) r_state <= ST_DONE;
          default: begin
            r_state     <= ST_IDLE;
            r_sel_valid <= 1'b0;
          end
        endcase
      end
    end
  for (genvar i = 0; i < NUM_EP; i++) begin : g_ep
    assign w_hit[i]                = r_sel_valid && r_sel == usb2_sel_t'(i);
    assign w_clr[i]                = w_hit[i] && r_state == ST_DONE;
    assign ep_xfer_in[i]           = w_hit[i] & xfer_in;
    assign ep_xfer_out[i]          = w_hit[i] & xfer_out;
    assign ep_xfer_pid[4*i +: 4]   = w_hit[i] ? xfer_pid : 4'd0;
    assign ep_buf_in_wren[i]       = w_hit[i] & buf_in_wren;
    usb2_ep_ready_track u_track (
      .phy_clk  (phy_clk),
      .reset_n  (reset_n),
      .ready    (ep_xfer_ready[i]),
      .clr      (w_clr[i]),
      .soft_rst (se0_reset),
      .err_clr  (err_clr),
      .latch    (w_latch[i]),
      .err      (err_missed_ep_ready[i])
    );
  end
  always_comb begin
    buf_out_q   = '0;
    buf_out_len = '0;
    xfer_ready  = 1'b0;
    for (int k = 0; k < NUM_EP; k++)
      if (w_hit[k]) begin
        buf_out_q   = ep_buf_out_q[8*k +: 8];
        buf_out_len = ep_buf_out_len[LEN_W*k +: LEN_W];
        xfer_ready  = w_latch[k];
      end
  end
  assign xfer_nak        = (r_state == ST_XFER_IN || r_state == ST_XFER_OUT) && !xfer_ready;
  // broadcasts held at zero until the reset release has been synchronised
  assign ep_buf_in_addr  = r_rst_sync[1] ? buf_in_addr : '0;
  assign ep_buf_in_data  = r_rst_sync[1] ? buf_in_data : '0;
  assign ep_buf_out_addr = r_rst_sync[1] ? buf_out_addr : '0;
endmodule

// File: tb/tb_usb2_ep_router.sv
// tb_usb2_ep_router: directed stimulus with a per-cycle behavioural model and hand-computed spot checks
module tb_usb2_ep_router;
  localparam int N = 4, AW = 9, LW = 10;
  logic clk = 1'b0, reset_n = 1'b0, se0_reset = 1'b0, xfer_in = 1'b0, xfer_out = 1'b0;
  logic [3:0] xfer_endp = '0, xfer_pid = '0;
  logic xfer_ready, xfer_nak;
  logic [AW-1:0] buf_in_addr = 9'h1A5, buf_out_addr = 9'h0F0;
  logic [7:0] buf_in_data = 8'h5A, buf_out_q;
  logic buf_in_wren = 1'b0, err_clr = 1'b0;
  logic [LW-1:0] buf_out_len;
  logic [N-1:0] ep_enable = 4'hF, ep_xfer_ready = '0;
  logic [N-1:0] ep_xfer_in, ep_xfer_out, ep_buf_in_wren, err_missed_ep_ready;
  logic [4*N-1:0] ep_xfer_pid;
  logic [AW-1:0] ep_buf_in_addr, ep_buf_out_addr;
  logic [7:0] ep_buf_in_data;
  logic [7:0] q_tab [N] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  logic [LW-1:0] len_tab [N] = '{10'd8, 10'd64, 10'd512, 10'd1023};
  logic [8*N-1:0] ep_buf_out_q;
  logic [LW*N-1:0] ep_buf_out_len;
  int checks = 0, errors = 0;
  int m_ph, m_sync;
  logic [3:0] m_sel, m_lat, m_err, h1, h2;
  logic m_val, pin, pout;

  always #5 clk = ~clk;
  assign ep_buf_out_q   = {q_tab[3], q_tab[2], q_tab[1], q_tab[0]};
  assign ep_buf_out_len = {len_tab[3], len_tab[2], len_tab[1], len_tab[0]};

  usb2_ep_router #(.NUM_EP(N), .ADDR_W(AW), .LEN_W(LW)) dut (
    .phy_clk(clk), .reset_n(reset_n), .se0_reset(se0_reset),
    .xfer_in(xfer_in), .xfer_out(xfer_out), .xfer_endp(xfer_endp), .xfer_pid(xfer_pid),
    .xfer_ready(xfer_ready), .xfer_nak(xfer_nak),
    .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
    .buf_out_addr(buf_out_addr), .buf_out_q(buf_out_q), .buf_out_len(buf_out_len),
    .ep_enable(ep_enable), .ep_xfer_in(ep_xfer_in), .ep_xfer_out(ep_xfer_out),
    .ep_xfer_pid(ep_xfer_pid), .ep_xfer_ready(ep_xfer_ready),
    .ep_buf_in_addr(ep_buf_in_addr), .ep_buf_in_data(ep_buf_in_data),
    .ep_buf_in_wren(ep_buf_in_wren), .ep_buf_out_addr(ep_buf_out_addr),
    .ep_buf_out_q(ep_buf_out_q), .ep_buf_out_len(ep_buf_out_len),
    .err_clr(err_clr), .err_missed_ep_ready(err_missed_ep_ready)
  );

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic look;
    @(negedge clk);
  endtask

  // reference behaviour, stepped on every active edge from the sampled inputs
  always @(posedge clk or negedge reset_n) begin : model
    logic [3:0] rise, clr, newe;
    if (!reset_n) begin
      m_ph = 0; m_sync = 0; m_sel = '0; m_val = 1'b0; m_lat = '0; m_err = '0;
      h1 = '0; h2 = '0; pin = 1'b0; pout = 1'b0;
    end else begin
      rise  = h1 & ~h2;
      clr   = (m_ph == 3 && m_val) ? 4'(1 << m_sel) : 4'd0;
      newe  = se0_reset ? 4'd0 : (rise & m_lat & ~clr);
      m_err = newe | (err_clr ? 4'd0 : m_err);
      m_lat = se0_reset ? 4'd0 : (rise | (m_lat & ~clr));
      if (se0_reset) begin
        m_ph = 0; m_val = 1'b0;
      end else if (m_ph == 0) begin
        if (m_sync >= 2 && ((xfer_in && !pin) || (xfer_out && !pout))) begin
          m_ph  = (xfer_in && !pin) ? 1 : 2;
          m_sel = xfer_endp;
          m_val = (xfer_endp < 4'(N)) && ep_enable[xfer_endp[1:0]];
        end
      end else if (m_ph == 1) begin
        if (!xfer_in) m_ph = 3;
      end else if (m_ph == 2) begin
        if (!xfer_out) m_ph = 3;
      end else begin
        m_ph = 0; m_val = 1'b0;
      end
      pin = xfer_in; pout = xfer_out; h2 = h1; h1 = ep_xfer_ready;
      if (m_sync < 2) m_sync++;
    end
  end

  always @(negedge clk) begin : cmp
    logic [3:0] hit;
    logic [15:0] e_pid;
    logic e_rdy;
    hit   = m_val ? 4'(1 << m_sel) : 4'd0;
    e_rdy = m_val && m_lat[m_sel[1:0]];
    e_pid = '0;
    for (int k = 0; k < N; k++) if (hit[k]) e_pid[4*k +: 4] = xfer_pid;
    chk("ep_xfer_in", 64'(ep_xfer_in), 64'(hit & {4{xfer_in}}));
    chk("ep_xfer_out", 64'(ep_xfer_out), 64'(hit & {4{xfer_out}}));
    chk("ep_wren", 64'(ep_buf_in_wren), 64'(hit & {4{buf_in_wren}}));
    chk("ep_pid", 64'(ep_xfer_pid), 64'(e_pid));
    chk("xfer_ready", 64'(xfer_ready), 64'(e_rdy));
    chk("xfer_nak", 64'(xfer_nak), 64'((m_ph == 1 || m_ph == 2) && !e_rdy));
    chk("buf_out_q", 64'(buf_out_q), 64'(m_val ? q_tab[m_sel[1:0]] : 8'd0));
    chk("buf_out_len", 64'(buf_out_len), 64'(m_val ? len_tab[m_sel[1:0]] : 10'd0));
    chk("err_missed", 64'(err_missed_ep_ready), 64'(m_err));
    chk("bcast_in_addr", 64'(ep_buf_in_addr), 64'(m_sync >= 2 ? buf_in_addr : 9'd0));
    chk("bcast_in_data", 64'(ep_buf_in_data), 64'(m_sync >= 2 ? buf_in_data : 8'd0));
    chk("bcast_out_addr", 64'(ep_buf_out_addr), 64'(m_sync >= 2 ? buf_out_addr : 9'd0));
  end

  initial begin
    look;
    chk("rst_addr", 64'(ep_buf_in_addr), 64'h0);
    chk("rst_nak", 64'(xfer_nak), 64'h0);
    tick(3); reset_n = 1'b1; tick(4);
    // endpoint 2 ready, then an OUT transaction routed to it
    ep_xfer_ready = 4'b0100; tick(3);
    xfer_out = 1'b1; xfer_endp = 4'd2; xfer_pid = 4'h9; tick(1);
    buf_in_wren = 1'b1; look;
    chk("t1_ep_out", 64'(ep_xfer_out), 64'h4);
    chk("t1_ready", 64'(xfer_ready), 64'h1);
    chk("t1_nak", 64'(xfer_nak), 64'h0);
    chk("t1_pid", 64'(ep_xfer_pid), 64'h0900);
    chk("t1_wren", 64'(ep_buf_in_wren), 64'h4);
    chk("t1_len", 64'(buf_out_len), 64'd512);
    tick(1); buf_in_wren = 1'b0; xfer_out = 1'b0; tick(1);
    look;
    chk("t1_done_ready", 64'(xfer_ready), 64'h1);
    tick(1); xfer_out = 1'b1; tick(1);
    look;
    chk("t1_latch_clr", 64'(xfer_ready), 64'h0);
    chk("t1_relatch_nak", 64'(xfer_nak), 64'h1);
    tick(1); xfer_out = 1'b0; tick(4);
    // absent endpoint 7
    xfer_in = 1'b1; xfer_endp = 4'd7; xfer_pid = 4'h3; tick(1);
    buf_in_wren = 1'b1; look;
    chk("t2_wren", 64'(ep_buf_in_wren), 64'h0);
    chk("t2_nak", 64'(xfer_nak), 64'h1);
    chk("t2_len", 64'(buf_out_len), 64'h0);
    tick(2); look;
    chk("t2_nak_hold", 64'(xfer_nak), 64'h1);
    tick(1); xfer_in = 1'b0; buf_in_wren = 1'b0; tick(4);
    // disabled endpoint 1, then enabled
    ep_enable = 4'b1101; xfer_in = 1'b1; xfer_endp = 4'd1; tick(1);
    look;
    chk("t3_dis_nak", 64'(xfer_nak), 64'h1);
    chk("t3_dis_in", 64'(ep_xfer_in), 64'h0);
    tick(1); xfer_in = 1'b0; tick(4);
    ep_enable = 4'hF; ep_xfer_ready = 4'b0110; tick(3);
    xfer_in = 1'b1; tick(1);
    look;
    chk("t3_en_in", 64'(ep_xfer_in), 64'h2);
    chk("t3_en_nak", 64'(xfer_nak), 64'h0);
    chk("t3_en_q", 64'(buf_out_q), 64'hB1);
    tick(1); xfer_in = 1'b0; tick(4);
    // two ready edges on endpoint 3
    ep_xfer_ready = 4'b1110; tick(3);
    ep_xfer_ready = 4'b0110; tick(2);
    ep_xfer_ready = 4'b1110; tick(3);
    look;
    chk("t4_err", 64'(err_missed_ep_ready), 64'h8);
    tick(1); err_clr = 1'b1; tick(1); err_clr = 1'b0;
    look;
    chk("t4_err_clr", 64'(err_missed_ep_ready), 64'h0);
    // simultaneous IN and OUT edges
    tick(1); xfer_in = 1'b1; xfer_out = 1'b1; xfer_endp = 4'd3; tick(1);
    look;
    chk("t5_in", 64'(ep_xfer_in), 64'h8);
    tick(1); xfer_out = 1'b0; tick(2);
    look;
    chk("t5_still_in", 64'(ep_xfer_in), 64'h8);
    chk("t5_nak", 64'(xfer_nak), 64'h0);
    tick(1); xfer_in = 1'b0; tick(4);
    // missed-ready on endpoint 1, then se0 in the middle of an OUT
    ep_xfer_ready = 4'b1100; tick(2);
    ep_xfer_ready = 4'b1110; tick(3);
    ep_xfer_ready = 4'b1100; tick(2);
    ep_xfer_ready = 4'b1110; tick(3);
    look;
    chk("t6_err", 64'(err_missed_ep_ready), 64'h2);
    tick(1); ep_xfer_ready = 4'b1111; tick(3);
    xfer_out = 1'b1; xfer_endp = 4'd0; tick(1);
    look;
    chk("t6_out", 64'(ep_xfer_out), 64'h1);
    tick(1); se0_reset = 1'b1; tick(1); se0_reset = 1'b0;
    look;
    chk("t6_se0_out", 64'(ep_xfer_out), 64'h0);
    chk("t6_se0_err", 64'(err_missed_ep_ready), 64'h2);
    tick(1); xfer_out = 1'b0; tick(4);
    xfer_out = 1'b1; tick(1);
    look;
    chk("t6_lat_clr", 64'(xfer_ready), 64'h0);
    tick(1); xfer_out = 1'b0; tick(4);
    // reset_n in the middle of an OUT
    xfer_out = 1'b1; xfer_endp = 4'd1; tick(2);
    reset_n = 1'b0; ep_xfer_ready = '0; xfer_out = 1'b0; #2;
    chk("t7_rst_out", 64'(ep_xfer_out), 64'h0);
    chk("t7_rst_err", 64'(err_missed_ep_ready), 64'h0);
    tick(3); reset_n = 1'b1; tick(5);
    xfer_out = 1'b1; tick(1);
    look;
    chk("t7_out", 64'(ep_xfer_out), 64'h2);
    chk("t7_lat_clr", 64'(xfer_ready), 64'h0);
    tick(1); xfer_out = 1'b0; tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
